// File: rtl/mem_io_responder.sv
// mem_io_responder: byte-wide RAM plus a memory-mapped UART TX FIFO, serving
// a memory controller one access per cycle.
//
// Ports
//   clk                         sole clock, rising edge
//   rst                         asynchronous, active-low reset
//   rdy                         global enable; low freezes all state
//   read_or_write_flag_from_mc  1 = write, 0 = read
//   access_address_from_mc      byte address
//   input_byte_from_mc          write data
//   output_byte_to_mc           read data, one cycle after the address (registered)
//   io_buffer_full_signal       TX FIFO nearly full (registered)
//   io_tx_valid / io_tx_byte    TX FIFO head, combinational from storage
//   io_tx_ready                 downstream consumes the head when high with valid
//   io_overflow                 sticky: a UART write was dropped
//
// Address map: below RAM_IO_ADDRESS is RAM (low RAM_ADDR_WIDTH bits used),
// RAM_IO_ADDRESS itself is the UART data port, everything else is ignored.
// RAM has no reset. Its contents can be preloaded in simulation from a hex
// init file into the ram array, or written through the bus.
module mem_io_responder #(
    parameter int unsigned RAM_ADDR_WIDTH = 17,
    parameter int unsigned IO_FIFO_DEPTH  = 8,
    parameter int unsigned IO_FULL_MARGIN = 2,
    parameter logic [31:0] RAM_IO_ADDRESS = 32'h30000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        read_or_write_flag_from_mc,
    input  logic [31:0] access_address_from_mc,
    input  logic [7:0]  input_byte_from_mc,
    output logic [7:0]  output_byte_to_mc,
    output logic        io_buffer_full_signal,
    output logic        io_tx_valid,
    output logic [7:0]  io_tx_byte,
    input  logic        io_tx_ready,
    output logic        io_overflow
);

    localparam int unsigned RAM_BYTES = 1 << RAM_ADDR_WIDTH;
    localparam int unsigned PTR_W     = $clog2(IO_FIFO_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;

    localparam logic [CNT_W-1:0] COUNT_MAX  = CNT_W'(IO_FIFO_DEPTH);
    localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'(IO_FIFO_DEPTH - IO_FULL_MARGIN);

    logic [7:0] ram [RAM_BYTES];
    logic [7:0] fifo_mem [IO_FIFO_DEPTH];

    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic [CNT_W-1:0]          count;
    logic [CNT_W-1:0]          count_next;
    logic [RAM_ADDR_WIDTH-1:0] ram_idx;

    logic is_ram;
    logic is_uart;
    logic ram_wr;
    logic ram_rd;
    logic push_req;
    logic push;
    logic pop;
    logic drop;

    // Address decode and access qualification
    always_comb begin
        is_ram   = access_address_from_mc < RAM_IO_ADDRESS;
        is_uart  = access_address_from_mc == RAM_IO_ADDRESS;
        ram_idx  = access_address_from_mc[RAM_ADDR_WIDTH-1:0];
        ram_wr   = rdy && read_or_write_flag_from_mc && is_ram;
        ram_rd   = !read_or_write_flag_from_mc && is_ram;
        push_req = rdy && read_or_write_flag_from_mc && is_uart;
    end

    // FIFO handshake; a full FIFO still accepts a push when the head leaves
    // in the same cycle.
    always_comb begin
        io_tx_valid = count != '0;
        io_tx_byte  = fifo_mem[rd_ptr];
        pop         = rdy && io_tx_valid && io_tx_ready;
        push        = push_req && ((count != COUNT_MAX) || pop);
        drop        = push_req && !push;
        count_next  = CNT_W'(count + CNT_W'(push) - CNT_W'(pop));
    end

    // RAM write port (no reset on storage)
    always_ff @(posedge clk) begin
        if (ram_wr) begin
            ram[ram_idx] <= input_byte_from_mc;
        end
    end

    // FIFO storage (no reset; validity is tracked by count)
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= input_byte_from_mc;
        end
    end

    // Read data: RAM byte one cycle later, zero for writes, UART and void
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            output_byte_to_mc <= 8'h00;
        end else if (rdy) begin
            output_byte_to_mc <= ram_rd ? ram[ram_idx] : 8'h00;
        end
    end

    // FIFO pointers, occupancy and flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr                <= '0;
            rd_ptr                <= '0;
            count                 <= '0;
            io_buffer_full_signal <= 1'b0;
            io_overflow           <= 1'b0;
        end else if (rdy) begin
            if (push) begin
                wr_ptr <= PTR_W'(wr_ptr + PTR_W'(1));
            end
            if (pop) begin
                rd_ptr <= PTR_W'(rd_ptr + PTR_W'(1));
            end
            count <= count_next;
            // The margin covers the controller seeing the flag one cycle late.
            io_buffer_full_signal <= count_next >= FULL_LEVEL;
            if (drop) begin
                io_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: a scoreboard of expected read bytes
// (latency 1) plus a queue model of the UART TX FIFO.
module tb_mem_io_responder;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned MARGIN  = 2;
    localparam logic [31:0] IO_ADDR = 32'h30000;
    localparam logic [31:0] RAM_MSK = 32'h1FFFF;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        rw_flag;
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        full;
    logic        tx_valid;
    logic [7:0]  tx_byte;
    logic        tx_ready;
    logic        overflow;

    int total;
    int bad;

    logic [7:0] model_ram [int];
    logic [7:0] rd_q [$];
    logic [7:0] tx_q [$];
    logic [7:0] last_exp;
    logic       full_m;
    logic       ovf_m;

    mem_io_responder #(
        .RAM_ADDR_WIDTH (17),
        .IO_FIFO_DEPTH  (DEPTH),
        .IO_FULL_MARGIN (MARGIN),
        .RAM_IO_ADDRESS (IO_ADDR)
    ) dut (
        .clk                        (clk),
        .rst                        (rst),
        .rdy                        (rdy),
        .read_or_write_flag_from_mc (rw_flag),
        .access_address_from_mc     (addr),
        .input_byte_from_mc         (wdata),
        .output_byte_to_mc          (rdata),
        .io_buffer_full_signal      (full),
        .io_tx_valid                (tx_valid),
        .io_tx_byte                 (tx_byte),
        .io_tx_ready                (tx_ready),
        .io_overflow                (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bus cycle: drive, predict, clock, then check against the scoreboard.
    task automatic step(input logic f, input logic [31:0] a, input logic [7:0] d,
                        input logic rd, input logic rv, input string tag);
        logic [7:0] e;
        logic       pop_m;
        logic       push_req;
        int         idx;
        rw_flag  = f;
        addr     = a;
        wdata    = d;
        tx_ready = rd;
        rdy      = rv;
        idx      = int'(a & RAM_MSK);
        if (!rv) e = last_exp;
        else if (!f && a < IO_ADDR) e = model_ram.exists(idx) ? model_ram[idx] : 8'h00;
        else e = 8'h00;
        last_exp = e;
        rd_q.push_back(e);

        total++;
        if (tx_valid !== (tx_q.size() != 0)) begin
            bad++;
            $display("FAIL %s tx_valid: got %b want %b", tag, tx_valid, tx_q.size() != 0);
        end
        if (tx_q.size() != 0) begin
            total++;
            if (tx_byte !== tx_q[0]) begin
                bad++;
                $display("FAIL %s tx_byte: got %h want %h", tag, tx_byte, tx_q[0]);
            end
        end

        pop_m    = rv && rd && (tx_q.size() != 0);
        push_req = rv && f && (a == IO_ADDR);
        if (pop_m) void'(tx_q.pop_front());
        if (push_req) begin
            if (tx_q.size() < DEPTH) tx_q.push_back(d);
            else ovf_m = 1'b1;
        end
        if (rv) full_m = tx_q.size() >= (DEPTH - MARGIN);
        if (rv && f && a < IO_ADDR) model_ram[idx] = d;

        @(posedge clk);
        #1;
        e = rd_q.pop_front();
        total++;
        if (rdata !== e) begin
            bad++;
            $display("FAIL %s rdata: got %h want %h", tag, rdata, e);
        end
        total++;
        if (full !== full_m) begin
            bad++;
            $display("FAIL %s full: got %b want %b", tag, full, full_m);
        end
        total++;
        if (overflow !== ovf_m) begin
            bad++;
            $display("FAIL %s overflow: got %b want %b", tag, overflow, ovf_m);
        end
    endtask

    task automatic model_clear();
        tx_q.delete();
        rd_q.delete();
        full_m   = 1'b0;
        ovf_m    = 1'b0;
        last_exp = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b0; rdy = 1'b0; rw_flag = 1'b0; addr = '0; wdata = '0; tx_ready = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({rdata, full, tx_valid, overflow} !== 11'h0) begin
            bad++;
            $display("FAIL reset_outputs: got %h/%b/%b/%b want 00/0/0/0", rdata, full, tx_valid, overflow);
        end
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        step(1'b0, 32'h0, 8'h00, 1'b0, 1'b1, "post_reset_idle");
    endtask

    task automatic test_ram_rw();
        step(1'b1, 32'h00010, 8'hA5, 1'b0, 1'b1, "wr_10");
        step(1'b0, 32'h00010, 8'h00, 1'b0, 1'b1, "rd_10");
        step(1'b0, 32'h20010, 8'h00, 1'b0, 1'b1, "rd_alias_10");
        step(1'b1, 32'h00011, 8'h3C, 1'b0, 1'b1, "wr_11");
        step(1'b1, 32'h40000, 8'hFF, 1'b0, 1'b1, "wr_void");
        step(1'b0, 32'h40000, 8'h00, 1'b0, 1'b1, "rd_void");
        step(1'b0, IO_ADDR,   8'h00, 1'b0, 1'b1, "rd_uart");
        step(1'b0, 32'h00011, 8'h00, 1'b0, 1'b1, "rd_11");
        total++;
        if (rdata !== 8'h3C) begin
            bad++;
            $display("FAIL rd_11_const: got %h want 3c", rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pat [4];
        pat[0] = 8'h13; pat[1] = 8'h57; pat[2] = 8'h9B; pat[3] = 8'hDF;
        for (int i = 0; i < 4; i++) step(1'b1, 32'h100 + 32'(i), pat[i], 1'b0, 1'b1, "b2b_wr");
        for (int i = 0; i < 4; i++) step(1'b0, 32'h100 + 32'(i), 8'h00, 1'b0, 1'b1, "b2b_rd");
        step(1'b1, 32'h101, 8'h66, 1'b0, 1'b1, "raw_wr");
        step(1'b0, 32'h101, 8'h00, 1'b0, 1'b1, "raw_rd");
    endtask

    task automatic test_rdy_hold();
        step(1'b0, 32'h102, 8'h00, 1'b0, 1'b1, "hold_pre");
        step(1'b1, 32'h102, 8'h00, 1'b1, 1'b0, "hold_wr");
        step(1'b1, IO_ADDR, 8'h77, 1'b1, 1'b0, "hold_uart");
        step(1'b0, 32'h102, 8'h00, 1'b0, 1'b1, "hold_after");
    endtask

    task automatic test_fifo_full();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, IO_ADDR, 8'hB0 + 8'(i), 1'b0, 1'b1, "fill6");
            if (i == 4) begin
                total++;
                if (full !== 1'b0) begin
                    bad++;
                    $display("FAIL full_after5: got %b want 0", full);
                end
            end
        end
        total++;
        if (full !== 1'b1) begin
            bad++;
            $display("FAIL full_after6: got %b want 1", full);
        end
        step(1'b1, IO_ADDR, 8'hB6, 1'b0, 1'b1, "fill7");
        step(1'b1, IO_ADDR, 8'hB7, 1'b0, 1'b1, "fill8");
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_at8: got %b want 0", overflow);
        end
        step(1'b1, IO_ADDR, 8'hB8, 1'b0, 1'b1, "fill9_drop");
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_after9: got %b want 1", overflow);
        end
    endtask

    task automatic test_full_push_pop();
        step(1'b1, IO_ADDR, 8'hEE, 1'b1, 1'b1, "full_push_pop");
        step(1'b0, 32'h0, 8'h00, 1'b0, 1'b1, "full_pp_idle");
        step(1'b1, IO_ADDR, 8'hEF, 1'b0, 1'b1, "full_again_drop");
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 8'h00, 1'b1, 1'b1, "drain5");
    endtask

    task automatic test_reset_mid();
        #2 rst = 1'b0;
        #1;
        total++;
        if ({tx_valid, full, overflow, rdata} !== 11'h0) begin
            bad++;
            $display("FAIL async_reset: got %b/%b/%b/%h want 0/0/0/00", tx_valid, full, overflow, rdata);
        end
        model_clear();
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        step(1'b0, 32'h00010, 8'h00, 1'b1, 1'b1, "post_mid_rd");
        step(1'b1, IO_ADDR, 8'h5A, 1'b0, 1'b1, "post_mid_push");
        step(1'b0, 32'h0, 8'h00, 1'b1, 1'b1, "post_mid_pop");
        step(1'b0, 32'h0, 8'h00, 1'b0, 1'b1, "post_mid_empty");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_ram_rw();
        test_back_to_back();
        test_rdy_hold();
        test_fifo_full();
        test_full_push_pop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_io_responder.md
MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 SHALL have parameter RAM_ADDR_WIDTH, default 17, meaning RAM is 2^RAM_ADDR_WIDTH bytes.
REQ-002 SHALL have parameter IO_FIFO_DEPTH, default 8, meaning UART TX FIFO entries; it must be a power of two, >= 4.
REQ-003 SHALL have parameter IO_FULL_MARGIN, default 2, meaning free-slot reserve kept when full is flagged.
REQ-004 SHALL have parameter RAM_IO_ADDRESS, default 32'h30000, meaning the UART data address.
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 rdy  in  1  global enable; low freezes all state.
REQ-008 read_or_write_flag_from_mc  in  1  1 = write, 0 = read.
REQ-009 access_address_from_mc  in  32  byte address from memory controller.
REQ-010 input_byte_from_mc  in  8  write data byte.
REQ-011 output_byte_to_mc  out  8  read data byte, registered.
REQ-012 io_buffer_full_signal  out  1  TX FIFO nearly full, registered.
REQ-013 io_tx_valid  out  1  TX FIFO head byte available.
REQ-014 io_tx_byte  out  8  TX FIFO head byte.
REQ-015 io_tx_ready  in  1  downstream UART consumes head when high with io_tx_valid.
REQ-016 io_overflow  out  1  sticky: a UART write was dropped.

Function
REQ-017 Address decode SHALL be: RAM when address < RAM_IO_ADDRESS; UART when address == RAM_IO_ADDRESS; all other addresses are "void".
REQ-018 RAM access SHALL use address bits [RAM_ADDR_WIDTH-1:0]; upper bits are ignored.
REQ-019 RAM reads SHALL have latency 1: address A presented in cycle N -> ram[A] on output_byte_to_mc in cycle N+1, every cycle, pipelined without bubbles.
REQ-020 Reads of UART or void addresses SHALL return 8'h00 in cycle N+1.
REQ-021 A RAM write with flag = 1 in cycle N SHALL update ram[A] at the end of cycle N.
REQ-022 A read of A in cycle N+1 SHALL return the byte written in cycle N.
REQ-023 A write cycle SHALL drive output_byte_to_mc to 8'h00 in cycle N+1.
REQ-024 Void-address writes SHALL be ignored.
REQ-025 A UART write with the FIFO not full SHALL push input_byte_from_mc at the tail.
REQ-026 A UART write with the FIFO full (count == IO_FIFO_DEPTH) SHALL drop the byte and set io_overflow; io_overflow clears only on reset.
REQ-027 Pop SHALL occur when io_tx_valid && io_tx_ready.
REQ-028 io_tx_valid = (count != 0); io_tx_byte = head entry, combinational from FIFO storage.
REQ-029 Push and pop in the same cycle SHALL leave count unchanged and both SHALL take effect; this holds even when count == IO_FIFO_DEPTH.
REQ-030 Pop when empty SHALL be impossible, because valid is low.
REQ-031 Read/write pointers SHALL be log2(IO_FIFO_DEPTH) bits and wrap modulo depth.
REQ-032 count SHALL be log2(IO_FIFO_DEPTH)+1 bits, range 0..IO_FIFO_DEPTH.
REQ-033 io_buffer_full_signal SHALL be registered as (count_next >= IO_FIFO_DEPTH - IO_FULL_MARGIN), where count_next is the post-update count.
REQ-034 The margin in REQ-033 SHALL absorb the controller's one-cycle reaction delay, so consecutive back-to-back UART writes never overflow while the flag is honoured.
REQ-035 rdy = 0 SHALL hold: no RAM write, no push/pop, and output_byte_to_mc, pointers, count and flags all hold.
REQ-036 While rdy = 0, io_tx_valid/io_tx_byte SHALL stay stable and io_tx_ready SHALL be ignored.
REQ-037 Address/flag presented while rdy = 0 SHALL have no effect.

Reset
REQ-038 rst low SHALL immediately set output_byte_to_mc = 8'h00, io_buffer_full_signal = 0, io_overflow = 0, count = 0, pointers = 0, io_tx_valid = 0.
REQ-039 RAM contents SHALL NOT be reset; RAM SHALL be preloadable from a hex init file for simulation.
REQ-040 Reset asserted mid-stream SHALL discard FIFO contents; the first cycle after release SHALL behave as idle with the FIFO empty.

Verification
REQ-041 Write 8'hA5 to 0x00010 in cycle N, read 0x00010 in cycle N+1 -> output_byte_to_mc = 8'hA5 in cycle N+2.
REQ-042 Back-to-back reads of 0x100..0x103 preloaded 13,57,9B,DF -> bytes 13,57,9B,DF on four consecutive cycles, one cycle after each address.
REQ-043 Depth 8, margin 2, io_tx_ready = 0, six UART writes -> io_buffer_full_signal rises the cycle after the 6th push.
REQ-044 Continuing REQ-043 with two more writes then a ninth -> count 8; ninth byte dropped; io_overflow = 1.
REQ-045 Full FIFO, simultaneous UART write and io_tx_ready = 1 -> count stays 8; head advances; new byte at tail; io_overflow unchanged.
REQ-046 Async reset pulse mid-drain with 3 bytes queued -> io_tx_valid = 0 and full = 0 immediately; a RAM byte written earlier is still readable after release.
